// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues 1-cycle imem reads, buffers words in a prefetch FIFO.
// Optional build macro FETCH_PERF_EN adds perf_fetched / perf_bubbles counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ADDR_W     = 10,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [31:0]       id_inst,
  output logic [31:0]       id_pc,
  output logic [31:0]       id_pc4,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_bubbles
`endif
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fq_entry_t;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   tag_pc_q, tag_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  fq_entry_t     fifo_q [FIFO_DEPTH];
  fq_entry_t     fifo_d [FIFO_DEPTH];

  fq_entry_t     head;
  logic          pop, push, issue;
  logic [CW:0]   credit_used;

  always_comb begin
    head     = fifo_q[rd_ptr_q];
    id_valid = (count_q != '0);
    pop      = id_valid && id_ready;
    // A slot being popped this cycle is free again for the word returning next cycle.
    credit_used = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    issue    = rst && !redirect_valid && (credit_used < DEPTH_C);
    push     = inflight_q && !redirect_valid;

    imem_req  = issue;
    imem_addr = rst ? fetch_pc_q[ADDR_W+1:2] : '0;
    id_inst   = id_valid ? head.inst : '0;
    id_pc     = id_valid ? head.pc : '0;
    id_pc4    = id_valid ? (head.pc + 32'd4) : '0;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = issue;
    tag_pc_d   = tag_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    fifo_d     = fifo_q;

    if (issue) begin
      tag_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    if (push) fifo_d[wr_ptr_q] = '{inst: imem_rdata, pc: tag_pc_q};

    if (redirect_valid) begin
      // Flush: buffered words and the outstanding return are both discarded.
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push);
      count_d  = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      tag_pc_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      tag_pc_q   <= tag_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      fifo_q     <= fifo_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_bubbles_q, perf_bubbles_d;

  // Redirects do not clear these; a pop in the redirect cycle still counts.
  always_comb begin
    perf_fetched_d = perf_fetched_q + {31'd0, pop};
    perf_bubbles_d = perf_bubbles_q + {31'd0, (id_ready && !id_valid)};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched_q <= '0;
      perf_bubbles_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_bubbles_q <= perf_bubbles_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_bubbles = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run against a PC-stream model.
module tb_fetch_unit;
  localparam int          ADDR_W     = 10;
  localparam int          FIFO_DEPTH = 2;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata = '0;
  logic              id_valid;
  logic              id_ready = 1'b0;
  logic [31:0]       id_inst, id_pc, id_pc4;
  logic              redirect_valid = 1'b0;
  logic [31:0]       redirect_pc = '0;
`ifdef FETCH_PERF_EN
  logic [31:0]       perf_fetched, perf_bubbles;
`endif

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_inst(id_inst), .id_pc(id_pc), .id_pc4(id_pc4),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
  );

  function automatic logic [31:0] rom(input logic [ADDR_W-1:0] a);
    return 32'h1000_0000 + 32'(a);
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] pc);
    logic [ADDR_W-1:0] a;
    a = pc[ADDR_W+1:2];
    return rom(a);
  endfunction

  // Synchronous ROM; garbage on cycles without a request so stray captures are visible.
  always @(posedge clk) imem_rdata <= imem_req ? rom(imem_addr) : $urandom;

  task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    id_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic release_rst(input logic rdy);
    @(negedge clk);
    rst = 1'b1; id_ready = rdy; redirect_valid = 1'b0; redirect_pc = '0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_run++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", imem_req); end
    n_run++; if (imem_addr !== '0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", imem_addr); end
    n_run++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", id_valid); end
    n_run++; if (id_inst !== '0) begin n_fail++; $display("FAIL reset_inst got %h exp 0", id_inst); end
    n_run++; if (id_pc !== '0) begin n_fail++; $display("FAIL reset_pc got %h exp 0", id_pc); end
    n_run++; if (id_pc4 !== '0) begin n_fail++; $display("FAIL reset_pc4 got %h exp 0", id_pc4); end
  endtask

  task automatic test_startup();
    logic [31:0] e;
    do_reset();
    release_rst(1'b1);
    n_run++; if (imem_req !== 1'b1 || imem_addr !== 10'd0) begin n_fail++; $display("FAIL start_c0_req got %b/%h exp 1/0", imem_req, imem_addr); end
    n_run++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL start_c0_valid got %b exp 0", id_valid); end
    cyc(1'b1, 1'b0, '0);
    n_run++; if (imem_req !== 1'b1 || imem_addr !== 10'd1) begin n_fail++; $display("FAIL start_c1_req got %b/%h exp 1/1", imem_req, imem_addr); end
    n_run++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL start_c1_valid got %b exp 0", id_valid); end
    for (int k = 2; k <= 5; k++) begin
      cyc(1'b1, 1'b0, '0);
      e = 32'((k - 2) * 4);
      n_run++; if (id_valid !== 1'b1 || id_pc !== e) begin n_fail++; $display("FAIL start_pc c%0d got %b/%h exp 1/%h", k, id_valid, id_pc, e); end
      n_run++; if (id_inst !== 32'h1000_0000 + 32'(k - 2)) begin n_fail++; $display("FAIL start_inst c%0d got %h exp %h", k, id_inst, 32'h1000_0000 + 32'(k - 2)); end
      n_run++; if (id_pc4 !== e + 32'd4) begin n_fail++; $display("FAIL start_pc4 c%0d got %h exp %h", k, id_pc4, e + 32'd4); end
      n_run++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL start_throughput c%0d req got %b exp 1", k, imem_req); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    release_rst(1'b1);
    repeat (5) cyc(1'b1, 1'b0, '0);  // pops PCs 0..12
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, 1'b0, '0);
      n_run++; if (id_valid !== 1'b1 || id_pc !== 32'd16) begin n_fail++; $display("FAIL stall_hold c%0d got %b/%h exp 1/10", k, id_valid, id_pc); end
      n_run++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req c%0d got %b exp 0", k, imem_req); end
    end
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, 1'b0, '0);
      n_run++; if (id_valid !== 1'b1 || id_pc !== 32'(16 + 4 * k)) begin n_fail++; $display("FAIL stall_resume c%0d got %b/%h exp 1/%h", k, id_valid, id_pc, 32'(16 + 4 * k)); end
    end
  endtask

  task automatic test_redirect();
    for (int rc = 1; rc <= 3; rc++) begin
      do_reset();
      release_rst(1'b0);
      for (int k = 1; k < rc; k++) cyc(1'b0, 1'b0, '0);
      cyc(1'b0, 1'b1, 32'h40);
      n_run++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redir%0d_R_req got %b exp 0", rc, imem_req); end
      cyc(1'b1, 1'b0, '0);
      n_run++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL redir%0d_R1_valid got %b exp 0", rc, id_valid); end
      n_run++; if (imem_req !== 1'b1 || imem_addr !== 10'd16) begin n_fail++; $display("FAIL redir%0d_R1_req got %b/%h exp 1/10", rc, imem_req, imem_addr); end
      cyc(1'b1, 1'b0, '0);
      n_run++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL redir%0d_R2_valid got %b exp 0", rc, id_valid); end
      cyc(1'b1, 1'b0, '0);
      n_run++; if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_inst !== rom(10'd16) || id_pc4 !== 32'h44) begin
        n_fail++; $display("FAIL redir%0d_R3 got %b/%h/%h/%h exp 1/40/%h/44", rc, id_valid, id_pc, id_inst, id_pc4, rom(10'd16)); end
      cyc(1'b1, 1'b0, '0);
      n_run++; if (id_valid !== 1'b1 || id_pc !== 32'h44) begin n_fail++; $display("FAIL redir%0d_R4 got %b/%h exp 1/44", rc, id_valid, id_pc); end
    end
  endtask

  task automatic test_unaligned();
    do_reset();
    release_rst(1'b1);
    repeat (3) cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b1, 32'h43);
    n_run++; if (id_valid !== 1'b1 || id_pc !== 32'd8) begin n_fail++; $display("FAIL unal_R_pop got %b/%h exp 1/8", id_valid, id_pc); end
    cyc(1'b1, 1'b0, '0);
    n_run++; if (imem_req !== 1'b1 || imem_addr !== 10'd16) begin n_fail++; $display("FAIL unal_addr got %b/%h exp 1/10", imem_req, imem_addr); end
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    n_run++; if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_inst !== rom(10'd16)) begin n_fail++; $display("FAIL unal_pc got %b/%h/%h exp 1/40/%h", id_valid, id_pc, id_inst, rom(10'd16)); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    release_rst(1'b1);
    repeat (3) cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b1, 32'h100);
    n_run++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL b2b_R_req got %b exp 0", imem_req); end
    cyc(1'b1, 1'b1, 32'h200);
    n_run++; if (imem_req !== 1'b0 || id_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_R2 got req %b valid %b exp 0/0", imem_req, id_valid); end
    cyc(1'b1, 1'b0, '0);
    n_run++; if (imem_req !== 1'b1 || imem_addr !== 10'd128 || id_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_R3 got %b/%h/%b exp 1/80/0", imem_req, imem_addr, id_valid); end
    cyc(1'b1, 1'b0, '0);
    n_run++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_R4_valid got %b exp 0", id_valid); end
    cyc(1'b1, 1'b0, '0);
    n_run++; if (id_valid !== 1'b1 || id_pc !== 32'h200 || id_inst !== rom(10'd128)) begin n_fail++; $display("FAIL b2b_deliver got %b/%h/%h exp 1/200/%h", id_valid, id_pc, id_inst, rom(10'd128)); end
    cyc(1'b1, 1'b0, '0);
    n_run++; if (id_valid !== 1'b1 || id_pc !== 32'h204) begin n_fail++; $display("FAIL b2b_next got %b/%h exp 1/204", id_valid, id_pc); end
  endtask

  task automatic test_wrap();
    do_reset();
    release_rst(1'b1);
    repeat (2) cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b1, 32'hFFFF_FFF8);
    cyc(1'b1, 1'b0, '0);
    n_run++; if (imem_addr !== 10'h3FE) begin n_fail++; $display("FAIL wrap_addr0 got %h exp 3fe", imem_addr); end
    cyc(1'b1, 1'b0, '0);
    n_run++; if (imem_addr !== 10'h3FF) begin n_fail++; $display("FAIL wrap_addr1 got %h exp 3ff", imem_addr); end
    cyc(1'b1, 1'b0, '0);
    n_run++; if (id_pc !== 32'hFFFF_FFF8 || id_pc4 !== 32'hFFFF_FFFC || id_inst !== 32'h1000_03FE) begin n_fail++; $display("FAIL wrap_d0 got %h/%h/%h exp fffffff8/fffffffc/100003fe", id_pc, id_pc4, id_inst); end
    n_run++; if (imem_req !== 1'b1 || imem_addr !== 10'h000) begin n_fail++; $display("FAIL wrap_addr2 got %b/%h exp 1/0", imem_req, imem_addr); end
    cyc(1'b1, 1'b0, '0);
    n_run++; if (id_pc !== 32'hFFFF_FFFC || id_pc4 !== 32'h0) begin n_fail++; $display("FAIL wrap_d1 got %h/%h exp fffffffc/0", id_pc, id_pc4); end
    cyc(1'b1, 1'b0, '0);
    n_run++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_inst !== rom(10'd0)) begin n_fail++; $display("FAIL wrap_d2 got %b/%h/%h exp 1/0/%h", id_valid, id_pc, id_inst, rom(10'd0)); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    release_rst(1'b1);
    repeat (4) cyc(1'b1, 1'b0, '0);
    @(negedge clk);
    id_ready = 1'b1;
    #1;
    n_run++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_valid got %b exp 1", id_valid); end
    #1; rst = 1'b0; #1;
    n_run++; if (id_valid !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL rmid_async got valid %b req %b exp 0/0", id_valid, imem_req); end
    n_run++; if (id_pc !== '0 || imem_addr !== '0) begin n_fail++; $display("FAIL rmid_async_pc got %h/%h exp 0/0", id_pc, imem_addr); end
    repeat (2) @(negedge clk);
    release_rst(1'b1);
    n_run++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC[ADDR_W+1:2]) begin n_fail++; $display("FAIL rmid_c0 got %b/%h exp 1/%h", imem_req, imem_addr, RESET_PC[ADDR_W+1:2]); end
    cyc(1'b1, 1'b0, '0);
    n_run++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_c1_valid got %b exp 0", id_valid); end
    cyc(1'b1, 1'b0, '0);
    n_run++; if (id_valid !== 1'b1 || id_pc !== RESET_PC || id_inst !== exp_inst(RESET_PC)) begin n_fail++; $display("FAIL rmid_first got %b/%h/%h exp 1/%h/%h", id_valid, id_pc, id_inst, RESET_PC, exp_inst(RESET_PC)); end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, rpc, last_tgt;
    logic        rdy, rv, prev_hold, prev_rv;
    int          blank, pops;
    do_reset();
    release_rst(1'b1);
    exp_pc = RESET_PC; blank = 0; pops = 0; prev_hold = 1'b0; prev_rv = 1'b0; last_tgt = '0;
    // The release cycle itself: nothing to deliver yet.
    for (int c = 0; c < 3000; c++) begin
      if (c == 0) begin
        rdy = 1'b1; rv = 1'b0; rpc = '0;
      end else begin
        rdy = ($urandom_range(0, 9) < 7);
        rv  = ($urandom_range(0, 19) == 0);
        rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
        cyc(rdy, rv, rpc);
      end
      if (rv) begin
        n_run++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rnd_req_on_redirect c%0d got %b exp 0", c, imem_req); end
      end else if (prev_rv) begin
        n_run++; if (imem_req !== 1'b1 || imem_addr !== last_tgt[ADDR_W+1:2]) begin n_fail++; $display("FAIL rnd_first_req c%0d got %b/%h exp 1/%h", c, imem_req, imem_addr, last_tgt[ADDR_W+1:2]); end
      end
      if (blank > 0) begin
        n_run++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_blank c%0d got valid %b exp 0", c, id_valid); end
      end
      if (prev_hold) begin
        n_run++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL rnd_hold c%0d got valid %b exp 1", c, id_valid); end
      end
      if (id_valid === 1'b1) begin
        n_run++; if (id_pc !== exp_pc || id_inst !== exp_inst(exp_pc) || id_pc4 !== exp_pc + 32'd4) begin
          n_fail++; $display("FAIL rnd_data c%0d got %h/%h/%h exp %h/%h/%h", c, id_pc, id_inst, id_pc4, exp_pc, exp_inst(exp_pc), exp_pc + 32'd4); end
        if (rdy) begin exp_pc = exp_pc + 32'd4; pops++; end
      end
      if (blank > 0) blank--;
      if (rv) begin
        exp_pc = {rpc[31:2], 2'b00}; last_tgt = exp_pc; blank = 2;
      end
      prev_hold = (id_valid === 1'b1) && !rdy && !rv;
      prev_rv = rv;
    end
    n_run++; if (pops < 500) begin n_fail++; $display("FAIL rnd_progress got %0d pops exp >=500", pops); end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    do_reset();
    release_rst(1'b1);                           // bubble 1
    cyc(1'b1, 1'b0, '0);                         // bubble 2
    repeat (10) cyc(1'b1, 1'b0, '0);             // 10 pops
    cyc(1'b0, 1'b1, 32'h80);
    cyc(1'b1, 1'b0, '0);                         // bubble 3
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    n_run++; if (perf_fetched !== 32'd10) begin n_fail++; $display("FAIL perf_fetched got %0d exp 10", perf_fetched); end
    n_run++; if (perf_bubbles !== 32'd3) begin n_fail++; $display("FAIL perf_bubbles got %0d exp 3", perf_bubbles); end
  endtask
`endif

  initial begin
    test_reset();
    test_startup();
    test_stall();
    test_redirect();
    test_unaligned();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_random();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
